sram_bank_sched: RTL and testbench
==================================

SRAM_BANK_SCHED -- requirements
Module: sram_bank_sched

Interface
REQ-001 Parameter PHASES, default 5: Bennett clock phase count; sets EVAL and HOLD length in clk cycles.
REQ-002 Parameter AW, default 5: bank address width (32 words).
REQ-003 Parameter DW, default 16: bank data width.
REQ-004 Port clk, input, 1: single clock; all state on rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high.
REQ-006 Port instFlag, input, 1: instruction-window flag from the Bennett clock generator.
REQ-007 Ports rd_req in 1, rd_addr_a in AW, rd_addr_b in AW, rd_ready out 1: dual-read requester.
REQ-008 Ports rd_valid out 1, rd_data_a out DW, rd_data_b out DW: read result.
REQ-009 Ports wr_req in 1, wr_addr in AW, wr_data in DW, wr_ready out 1: write requester.
REQ-010 Ports bank_addr_a out AW, bank_addr_b out AW, bank_in out DW, bank_read_en out 1, bank_write_en out 1, bank_regwrt_bar out 1: bank drive.
REQ-011 Ports bank_out_a in DW, bank_out_b in DW: bank read data.
REQ-012 Port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, SETUP, EVAL and HOLD.
REQ-014 Launch condition: IDLE, any request pending, and inst_rise = instFlag high while the previous-cycle sample is low.
REQ-015 On launch, the grantee's ready SHALL pulse high for exactly that cycle, its payload SHALL be latched, and the FSM SHALL go to SETUP.
REQ-016 Arbitration: a lone request wins; on simultaneous requests the side not granted last wins (round-robin).
REQ-017 SETUP, 1 cycle: bank addresses and bank_in driven from the latch, enables low, regwrt_bar high.
REQ-018 EVAL, PHASES cycles: read op has read_en=1; write op has write_en=1 and regwrt_bar=0.
REQ-019 HOLD, PHASES cycles: enables low, regwrt_bar high, addresses and data held stable (Bennett un-compute), then IDLE.
REQ-020 Op length SHALL be 1+2*PHASES cycles (11 at default); next launch needs a new inst_rise.
REQ-021 Read op: bank_out_a/b captured on the last EVAL cycle into rd_data_a/b; rd_valid pulses 1 cycle on the first HOLD cycle.
REQ-022 Read op, write op: bank_addr_a=wr_addr, bank_addr_b=0, bank_in=wr_data; read op: bank_in=0.
REQ-023 In IDLE all bank_* outputs SHALL be zero except regwrt_bar=1.
REQ-024 Requester drops req before its ready pulse: no operation, no state change.
REQ-025 Requests arriving during an op SHALL wait, no ready, until the next eligible launch.
REQ-026 rd_data_a/b SHALL hold their last captured value until the next read capture.
REQ-027 rd_addr_a equal to rd_addr_b SHALL be legal: both outputs return the same word.
REQ-028 An inst_rise that arrives while busy SHALL be ignored, not queued.

Reset
REQ-029 Reset SHALL force IDLE, clear ready, rd_valid, rd_data and the payload latch, set bank outputs per REQ-023, and clear the instFlag sample register.
REQ-030 Reset mid-op SHALL abort it with no completion pulse.
REQ-031 After reset the round-robin pointer SHALL favour write.

Structure
REQ-032 A shared package SHALL hold the state enum, the op-type enum (OP_RD, OP_WR) and the default PHASES/AW/DW constants.
REQ-033 The round-robin arbiter SHALL be one sub-module, sram_sched_rr_arb (2 requesters, last-grant pointer).

Verification
REQ-034 Write: wr_req, addr 5'h03, data 16'hA5A5 at inst_rise -> wr_ready same cycle; write_en=1 and regwrt_bar=0 for 5 cycles after 1 SETUP; busy for 11 cycles.
REQ-035 Readback: after REQ-034, read of addr_a=3 and addr_b=3 -> rd_valid once, rd_data_a = rd_data_b = 16'hA5A5.
REQ-036 Contention: both requests at one inst_rise after reset -> write granted first; read granted at the next inst_rise.
REQ-037 No launch without edge: req held with instFlag constant high -> no ready; launch occurs only after instFlag toggles low then high.
REQ-038 Reset at the 3rd EVAL cycle -> next cycle IDLE, all enables 0, regwrt_bar=1, no rd_valid.
REQ-039 Retraction: rd_req pulsed between windows and dropped before inst_rise -> no grant, bank stays idle.

Source files
------------

// File: rtl/sram_bank_sched_pkg.sv
// Shared types and default geometry for the Bennett-clocked SRAM bank scheduler.
package sram_bank_sched_pkg;

  localparam int DEF_PHASES = 5;
  localparam int DEF_AW     = 5;
  localparam int DEF_DW     = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    EVAL,
    HOLD
  } sched_state_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_e;

endpackage

// File: rtl/sram_sched_rr_arb.sv
// Two-requester round-robin arbiter; req[0] is the reader, req[1] the writer.
module sram_sched_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // Index of the requester granted most recently; 0 after reset so the writer wins first.
  logic last_grant;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/sram_bank_sched.sv
// Schedules one read or write per instruction window onto an SRAM bank using a
// SETUP / EVAL / HOLD sequence sized by the Bennett clock phase count.
module sram_bank_sched
  import sram_bank_sched_pkg::*;
#(
  parameter int PHASES = DEF_PHASES,
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instFlag,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic          rd_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data_a,
  output logic [DW-1:0] rd_data_b,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic [AW-1:0] bank_addr_a,
  output logic [AW-1:0] bank_addr_b,
  output logic [DW-1:0] bank_in,
  output logic          bank_read_en,
  output logic          bank_write_en,
  output logic          bank_regwrt_bar,
  input  logic [DW-1:0] bank_out_a,
  input  logic [DW-1:0] bank_out_b,
  output logic          busy
);

  localparam int CW = $clog2(PHASES + 1);

  sched_state_e  state, state_nxt;
  logic [CW-1:0] phase_cnt;
  logic          last_phase;
  logic          inst_prev;
  logic          inst_rise;
  logic          launch;
  logic [1:0]    grant;

  op_e           lat_op;
  logic [AW-1:0] lat_addr_a;
  logic [AW-1:0] lat_addr_b;
  logic [DW-1:0] lat_data;

  assign inst_rise  = instFlag & ~inst_prev;
  assign launch     = (state == IDLE) & inst_rise & (rd_req | wr_req) & ~reset;
  assign last_phase = (phase_cnt == CW'(PHASES - 1));

  sram_sched_rr_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({wr_req, rd_req}),
    .advance (launch),
    .grant   (grant)
  );

  // Ready is a same-cycle handshake: it exists only in the launch cycle.
  assign rd_ready = launch & grant[0];
  assign wr_ready = launch & grant[1];
  assign busy     = (state != IDLE);

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = SETUP;
      SETUP:   state_nxt = EVAL;
      EVAL:    if (last_phase) state_nxt = HOLD;
      HOLD:    if (last_phase) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      phase_cnt  <= '0;
      inst_prev  <= 1'b0;
      lat_op     <= OP_RD;
      lat_addr_a <= '0;
      lat_addr_b <= '0;
      lat_data   <= '0;
      rd_valid   <= 1'b0;
      rd_data_a  <= '0;
      rd_data_b  <= '0;
    end else begin
      state     <= state_nxt;
      inst_prev <= instFlag;

      if (state_nxt != state) begin
        phase_cnt <= '0;
      end else if (state == EVAL || state == HOLD) begin
        phase_cnt <= phase_cnt + CW'(1);
      end

      if (launch) begin
        if (grant[1]) begin
          lat_op     <= OP_WR;
          lat_addr_a <= wr_addr;
          lat_addr_b <= '0;
          lat_data   <= wr_data;
        end else begin
          lat_op     <= OP_RD;
          lat_addr_a <= rd_addr_a;
          lat_addr_b <= rd_addr_b;
          lat_data   <= '0;
        end
      end

      // Capture on the last EVAL cycle so rd_valid lands on the first HOLD cycle.
      rd_valid <= (state == EVAL) && last_phase && (lat_op == OP_RD);
      if ((state == EVAL) && last_phase && (lat_op == OP_RD)) begin
        rd_data_a <= bank_out_a;
        rd_data_b <= bank_out_b;
      end
    end
  end

  always_comb begin
    bank_addr_a     = '0;
    bank_addr_b     = '0;
    bank_in         = '0;
    bank_read_en    = 1'b0;
    bank_write_en   = 1'b0;
    bank_regwrt_bar = 1'b1;
    if (state != IDLE) begin
      bank_addr_a = lat_addr_a;
      bank_addr_b = lat_addr_b;
      bank_in     = lat_data;
      if (state == EVAL) begin
        bank_read_en    = (lat_op == OP_RD);
        bank_write_en   = (lat_op == OP_WR);
        bank_regwrt_bar = (lat_op != OP_WR);
      end
    end
  end

endmodule

// File: tb/tb_sram_bank_sched.sv
// Randomised scoreboard bench for sram_bank_sched with a cycle-offset reference model.
module tb_sram_bank_sched;
  import sram_bank_sched_pkg::*;

  localparam int P     = 5;
  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int OPLEN = 1 + 2 * P;
  localparam int BW    = 2 * AW + DW + 3;

  logic          clk = 1'b0;
  logic          reset, instFlag;
  logic          rd_req, wr_req;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_ready, rd_valid, wr_ready, busy;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic [AW-1:0] bank_addr_a, bank_addr_b;
  logic [DW-1:0] bank_in, bank_out_a, bank_out_b;
  logic          bank_read_en, bank_write_en, bank_regwrt_bar;

  always #5 clk = ~clk;

  sram_bank_sched #(.PHASES(P), .AW(AW), .DW(DW)) dut (
    .clk             (clk),
    .reset           (reset),
    .instFlag        (instFlag),
    .rd_req          (rd_req),
    .rd_addr_a       (rd_addr_a),
    .rd_addr_b       (rd_addr_b),
    .rd_ready        (rd_ready),
    .rd_valid        (rd_valid),
    .rd_data_a       (rd_data_a),
    .rd_data_b       (rd_data_b),
    .wr_req          (wr_req),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_ready        (wr_ready),
    .bank_addr_a     (bank_addr_a),
    .bank_addr_b     (bank_addr_b),
    .bank_in         (bank_in),
    .bank_read_en    (bank_read_en),
    .bank_write_en   (bank_write_en),
    .bank_regwrt_bar (bank_regwrt_bar),
    .bank_out_a      (bank_out_a),
    .bank_out_b      (bank_out_b),
    .busy            (busy)
  );

  // Behavioural SRAM bank driven by the DUT.
  logic          fill_en;
  logic [DW-1:0] bank_mem [32];

  function automatic logic [DW-1:0] fill_val(int i);
    return DW'(i * 16'h0911 + 16'h3C5A);
  endfunction

  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < 32; i++) bank_mem[i] <= fill_val(i);
    end else if (bank_write_en) begin
      bank_mem[bank_addr_a] <= bank_in;
    end
  end
  assign bank_out_a = bank_mem[bank_addr_a];
  assign bank_out_b = bank_mem[bank_addr_b];

  // Scoreboard: kind 0 = wr_ready, 1 = rd_ready, 2 = rd_valid.
  typedef struct {
    int            kind;
    int            cyc;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } ev_t;
  ev_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic mon_en = 1'b0;

  // Reference model: op_cyc is the offset inside the current operation (0 = idle).
  int            op_cyc;
  logic          m_prev, m_last_wr, m_op_wr;
  logic [AW-1:0] m_a, m_b;
  logic [DW-1:0] m_in, m_rd_a, m_rd_b;
  logic [DW-1:0] ref_mem [32];
  logic          exp_busy;
  logic [BW-1:0] exp_bank;
  logic [2*DW-1:0] exp_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
  endtask

  task automatic pop_cmp(input int kind);
    ev_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event cyc=%0d actual=kind%0d expected=none", cyc, kind);
    end else begin
      e = sb_q.pop_front();
      check("event_kind", 64'(kind), 64'(e.kind));
      check("event_cycle", 64'(cyc), 64'(e.cyc));
      if (kind == 2) check("rd_valid_data", 64'({rd_data_a, rd_data_b}), 64'({e.a, e.b}));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("busy", 64'(busy), 64'(exp_busy));
        check("bank_drive", 64'({bank_addr_a, bank_addr_b, bank_in, bank_read_en,
                                 bank_write_en, bank_regwrt_bar}), 64'(exp_bank));
        check("rd_data_hold", 64'({rd_data_a, rd_data_b}), 64'(exp_rd));
        if (wr_ready) pop_cmp(0);
        if (rd_ready) pop_cmp(1);
        if (rd_valid) pop_cmp(2);
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
          n_checks++;
          $display("FAIL missed_event cyc=%0d actual=none expected=kind%0d", cyc, sb_q[0].kind);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic step(input logic r, input logic w, input logic inst, input logic rst);
    logic eval, launch, g_wr;
    rd_req = r; wr_req = w; instFlag = inst; reset = rst;
    cyc++;
    eval     = (op_cyc >= 2) && (op_cyc <= P + 1);
    exp_busy = (op_cyc != 0);
    if (op_cyc == 0) exp_bank = {AW'(0), AW'(0), DW'(0), 1'b0, 1'b0, 1'b1};
    else exp_bank = {m_a, m_b, m_in, !m_op_wr && eval, m_op_wr && eval, !(m_op_wr && eval)};
    exp_rd = {m_rd_a, m_rd_b};
    if (op_cyc == P + 2 && !m_op_wr) sb_q.push_back('{2, cyc, m_rd_a, m_rd_b});
    launch = (op_cyc == 0) && !rst && inst && !m_prev && (r || w);
    g_wr   = w && (!r || !m_last_wr);
    if (launch) sb_q.push_back('{g_wr ? 0 : 1, cyc, DW'(0), DW'(0)});
    @(posedge clk);
    if (m_op_wr && eval && op_cyc != 0) ref_mem[m_a] = m_in;
    if (rst) begin
      op_cyc = 0; m_prev = 1'b0; m_last_wr = 1'b0; m_rd_a = '0; m_rd_b = '0;
    end else begin
      if (op_cyc == P + 1 && !m_op_wr) begin
        m_rd_a = ref_mem[m_a];
        m_rd_b = ref_mem[m_b];
      end
      m_prev = inst;
      if (launch) begin
        op_cyc    = 1;
        m_last_wr = g_wr;
        m_op_wr   = g_wr;
        m_a       = g_wr ? wr_addr : rd_addr_a;
        m_b       = g_wr ? AW'(0) : rd_addr_b;
        m_in      = g_wr ? wr_data : DW'(0);
      end else if (op_cyc != 0) begin
        op_cyc = (op_cyc == OPLEN) ? 0 : op_cyc + 1;
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input logic inst);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, inst, 1'b0);
  endtask

  initial begin
    int   inst_cnt;
    logic inst_v;
    reset = 1'b1; instFlag = 1'b0; rd_req = 1'b0; wr_req = 1'b0; fill_en = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; wr_data = '0;
    op_cyc = 0; m_prev = 1'b0; m_last_wr = 1'b0; m_op_wr = 1'b0;
    m_a = '0; m_b = '0; m_in = '0; m_rd_a = '0; m_rd_b = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = fill_val(i);
    @(posedge clk); #1;

    fill_en = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    fill_en = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);

    // Write 16'hA5A5 to address 3, then read it back on both ports.
    wr_addr = 5'h03; wr_data = 16'hA5A5;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(13, 1'b1);
    idle(2, 1'b0);
    rd_addr_a = 5'h03; rd_addr_b = 5'h03;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(13, 1'b1);
    idle(2, 1'b0);

    // Contention after reset: writer first, reader only after a fresh rising edge.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    wr_addr = 5'h11; wr_data = 16'h1234; rd_addr_a = 5'h11; rd_addr_b = 5'h02;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    idle(13, 1'b1);
    idle(2, 1'b0);

    // Reset in the third EVAL cycle of a read aborts it silently.
    rd_addr_a = 5'h07; rd_addr_b = 5'h1F;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    idle(14, 1'b1);
    idle(2, 1'b0);

    // Retraction: request raised and dropped between windows.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b1);
    idle(2, 1'b0);

    inst_v = 1'b0; inst_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (inst_cnt == 0) begin
        inst_v   = ~inst_v;
        inst_cnt = int'($urandom_range(1, 15));
      end
      inst_cnt--;
      rd_addr_a = AW'($urandom_range(0, 31));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : AW'($urandom_range(0, 31));
      wr_addr   = AW'($urandom_range(0, 31));
      wr_data   = DW'($urandom);
      step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4, inst_v,
           $urandom_range(0, 299) == 0);
    end
    idle(16, 1'b0);
    check("scoreboard_drained", 64'(sb_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
